// File: rtl/pressure_monitor_scheduler_pkg.sv
// Shared types and constants for the pressure monitor scheduler and its
// per-channel confirmation FSMs.
package pressure_sched_pkg;

  localparam int DATA_W_DEF = 6;
  localparam int CNT_W      = 3;

  typedef enum logic [1:0] {
    NORMAL  = 2'd0,
    SUSPECT = 2'd1,
    ALARM   = 2'd2
  } ch_state_t;

endpackage

// File: rtl/pressure_monitor_scheduler_channel_fsm.sv
// Per-channel confirmation FSM: counts consecutive abnormal verdicts and
// raises a sticky alarm that only an acknowledge clears.
module pressure_channel_fsm
  import pressure_sched_pkg::*;
#(
  parameter int CONFIRM_CNT = 3
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      eval,
  input  logic      abnormal,
  input  logic      ack,
  output ch_state_t state,
  output logic      alarm,
  output logic      suspect
);

  localparam logic [CNT_W-1:0] CONFIRM        = CNT_W'(CONFIRM_CNT);
  localparam logic             FIRST_IS_ALARM = (CONFIRM_CNT == 1);
  localparam ch_state_t        FIRST_STATE    = FIRST_IS_ALARM ? ALARM : SUSPECT;

  ch_state_t        r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_alarm;
  logic             r_suspect;
  logic [CNT_W-1:0] w_cnt_inc;

  assign w_cnt_inc = (r_cnt == '1) ? r_cnt : r_cnt + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= NORMAL;
      r_cnt     <= '0;
      r_alarm   <= 1'b0;
      r_suspect <= 1'b0;
    end else begin
      case (r_state)
        NORMAL: begin
          if (eval && abnormal) begin
            r_state   <= FIRST_STATE;
            r_cnt     <= CNT_W'(1);
            r_alarm   <= FIRST_IS_ALARM;
            r_suspect <= !FIRST_IS_ALARM;
          end
        end
        SUSPECT: begin
          if (eval && !abnormal) begin
            r_state   <= NORMAL;
            r_cnt     <= '0;
            r_suspect <= 1'b0;
          end else if (eval && (w_cnt_inc == CONFIRM)) begin
            r_state   <= ALARM;
            r_cnt     <= CONFIRM;
            r_alarm   <= 1'b1;
            r_suspect <= 1'b0;
          end else if (eval) begin
            r_cnt <= w_cnt_inc;
          end
        end
        ALARM: begin
          // Ack takes effect before a same-edge sample, which then starts a new run.
          if (ack && eval && abnormal) begin
            r_state   <= FIRST_STATE;
            r_cnt     <= CNT_W'(1);
            r_alarm   <= FIRST_IS_ALARM;
            r_suspect <= !FIRST_IS_ALARM;
          end else if (ack) begin
            r_state   <= NORMAL;
            r_cnt     <= '0;
            r_alarm   <= 1'b0;
            r_suspect <= 1'b0;
          end
        end
        default: begin
          r_state   <= NORMAL;
          r_cnt     <= '0;
          r_alarm   <= 1'b0;
          r_suspect <= 1'b0;
        end
      endcase
    end
  end

  assign state   = r_state;
  assign alarm   = r_alarm;
  assign suspect = r_suspect;

endmodule

// File: rtl/pressure_monitor_scheduler.sv
// Round-robin scheduler sharing one abnormality detector across N_CH channels.
// Define ALARM_PRIORITY_EN to let SUSPECT channels win arbitration first.
module pressure_monitor_scheduler
  import pressure_sched_pkg::*;
#(
  parameter int N_CH        = 4,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int CONFIRM_CNT = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_CH-1:0]          req,
  input  logic [N_CH*DATA_W-1:0]   pressureIn,
  output logic [N_CH-1:0]          gnt,
  output logic [DATA_W-1:0]        detPressure,
  output logic                     detValid,
  input  logic                     detAbnormal,
  input  logic [N_CH-1:0]          alarmAck,
  output logic [N_CH-1:0]          alarm,
  output logic                     alarmAny,
  output logic [N_CH-1:0]          suspect
);

  localparam int PTR_W = (N_CH > 1) ? $clog2(N_CH) : 1;
`ifdef ALARM_PRIORITY_EN
  localparam logic PRIO_EN = 1'b1;
`else
  localparam logic PRIO_EN = 1'b0;
`endif

  // Handshake: req[i] is a pending sample; gnt[i] high means the sample and the
  // detector verdict are consumed at this clock edge. A req still high on the
  // following cycle is treated as a fresh request.
  logic [PTR_W-1:0] r_rr_ptr;
  logic [PTR_W-1:0] w_gnt_idx;
  logic             w_found;
  logic [N_CH-1:0]  w_gnt;
  logic [N_CH-1:0]  w_in_suspect;
  logic [N_CH-1:0]  w_prio_req;
  logic [N_CH-1:0]  w_alarm;
  logic [N_CH-1:0]  w_suspect;
  ch_state_t        w_state [N_CH];

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    assign w_in_suspect[i] = (w_state[i] == SUSPECT);

    pressure_channel_fsm #(
      .CONFIRM_CNT (CONFIRM_CNT)
    ) u_fsm (
      .clk      (clk),
      .rst      (rst),
      .eval     (w_gnt[i]),
      .abnormal (detAbnormal),
      .ack      (alarmAck[i]),
      .state    (w_state[i]),
      .alarm    (w_alarm[i]),
      .suspect  (w_suspect[i])
    );
  end

  assign w_prio_req = PRIO_EN ? (req & w_in_suspect) : '0;

  // Priority round first (empty unless enabled), then plain round-robin; both
  // scan from rrPtr+1 so a single pointer serves both.
  always_comb begin
    w_gnt     = '0;
    w_gnt_idx = '0;
    w_found   = 1'b0;
    for (int k = 1; k <= N_CH; k++) begin
      if (!w_found && w_prio_req[(int'(r_rr_ptr) + k) % N_CH]) begin
        w_found   = 1'b1;
        w_gnt_idx = PTR_W'((int'(r_rr_ptr) + k) % N_CH);
      end
    end
    for (int k = 1; k <= N_CH; k++) begin
      if (!w_found && req[(int'(r_rr_ptr) + k) % N_CH]) begin
        w_found   = 1'b1;
        w_gnt_idx = PTR_W'((int'(r_rr_ptr) + k) % N_CH);
      end
    end
    if (rst) begin
      w_found = 1'b0;
    end
    if (w_found) begin
      w_gnt[w_gnt_idx] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rr_ptr <= PTR_W'(N_CH - 1);
    end else if (w_found) begin
      r_rr_ptr <= w_gnt_idx;
    end
  end

  assign gnt         = w_gnt;
  assign detValid    = w_found;
  assign detPressure = w_found ? pressureIn[w_gnt_idx*DATA_W +: DATA_W] : '0;
  assign alarm       = w_alarm;
  assign suspect     = w_suspect;
  assign alarmAny    = |w_alarm;

endmodule
